// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// pc_op_t names the single operation chosen each cycle; decode_op
// resolves coinciding control strobes into that one operation.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_REL  = 3'd2,
        OP_ABS  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } pc_op_t;

    // Priority: stall > ret > call > branchAbs > branchRel > inc > hold
    function automatic pc_op_t decode_op(
        input logic stall,
        input logic ret,
        input logic call,
        input logic branch_abs,
        input logic branch_rel,
        input logic inc
    );
        pc_op_t op;
        if (stall) begin
            op = OP_HOLD;
        end else if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (branch_abs) begin
            op = OP_ABS;
        end else if (branch_rel) begin
            op = OP_REL;
        end else if (inc) begin
            op = OP_INC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack: register array plus a depth pointer.
// A push while full and a pop while empty are silently ignored; the
// caller is responsible for flagging those cases.
module pc_return_stack #(
    parameter int P_SIZE  = 6,
    parameter int P_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           nRst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [P_SIZE-1:0]              pushData,
    output logic [P_SIZE-1:0]              topData,
    output logic [$clog2(P_DEPTH+1)-1:0]   depth,
    output logic                           full,
    output logic                           empty
);
    localparam int DW = $clog2(P_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(P_DEPTH);

    logic [P_SIZE-1:0] mem_r [P_DEPTH];
    logic [DW-1:0]     depth_r;
    logic [DW-1:0]     depth_nxt_s;
    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic [P_SIZE-1:0] top_s;

    assign full_s    = (depth_r == DEPTH_MAX);
    assign empty_s   = (depth_r == {DW{1'b0}});
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    // Next depth: push or pop only when the stack can accept it
    always_comb begin
        depth_nxt_s = depth_r;
        if (push_ok_s) begin
            depth_nxt_s = depth_r + DEPTH_ONE;
        end else if (pop_ok_s) begin
            depth_nxt_s = depth_r - DEPTH_ONE;
        end else begin
            depth_nxt_s = depth_r;
        end
    end

    // Depth pointer register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            depth_r <= {DW{1'b0}};
        end else begin
            depth_r <= depth_nxt_s;
        end
    end

    // Entry storage: a push writes the slot just above the current top
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_r[i] <= {P_SIZE{1'b0}};
            end
        end else begin
            for (int i = 0; i < P_DEPTH; i++) begin
                if (push_ok_s && (depth_r == DW'(i))) begin
                    mem_r[i] <= pushData;
                end
            end
        end
    end

    // Top-of-stack read; zero when empty so the output is never undefined
    always_comb begin
        top_s = {P_SIZE{1'b0}};
        for (int i = 0; i < P_DEPTH; i++) begin
            if (depth_r == DW'(i + 1)) begin
                top_s = mem_r[i];
            end
        end
    end

    assign topData = top_s;
    assign depth   = depth_r;
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered address, next-address mux
// (inc / relative / absolute / call / return), return-address stack
// and overflow/underflow error flags.
// Optional build macro PC_SEQ_STICKY_ERR_EN: when defined the error
// flags latch until reset instead of pulsing for one cycle.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int P_SIZE       = 6,
    parameter int P_DEPTH      = 4,
    parameter int P_RESET_ADDR = 0,
    parameter int P_SIGNED_REL = 1
) (
    input  logic                          clk,
    input  logic                          nRst,
    output logic [P_SIZE-1:0]             addressOut,
    input  logic [P_SIZE-1:0]             branchAddress,
    input  logic                          inc,
    input  logic                          branchAbs,
    input  logic                          branchRel,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          stall,
    output logic [$clog2(P_DEPTH+1)-1:0]  stackDepth,
    output logic                          stackFull,
    output logic                          stackEmpty,
    output logic                          overflow,
    underflow
);
    localparam logic [P_SIZE-1:0] ADDR_ONE   = P_SIZE'(1);
    localparam logic [P_SIZE-1:0] ADDR_RESET = P_SIZE'(P_RESET_ADDR);

    pc_op_t            op_s;
    logic [P_SIZE-1:0] addr_r;
    logic [P_SIZE-1:0] addr_nxt_s;
    logic [P_SIZE-1:0] addr_inc_s;
    logic [P_SIZE:0]   off_ext_s;
    logic [P_SIZE-1:0] rel_sum_s;
    logic [P_SIZE-1:0] top_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic              ovf_nxt_s;
    logic              udf_nxt_s;
    logic              ovf_r;
    logic              udf_r;

    assign op_s       = decode_op(stall, ret, call, branchAbs, branchRel, inc);
    assign addr_inc_s = addr_r + ADDR_ONE;

    // Offset extension one bit wider than the address; the sum wraps
    generate
        if (P_SIGNED_REL != 0) begin : g_signed_rel
            assign off_ext_s = {branchAddress[P_SIZE-1], branchAddress};
        end else begin : g_unsigned_rel
            assign off_ext_s = {1'b0, branchAddress};
        end
    endgenerate
    assign rel_sum_s = P_SIZE'({1'b0, addr_r} + off_ext_s);

    pc_return_stack #(
        .P_SIZE  (P_SIZE),
        .P_DEPTH (P_DEPTH)
    ) u_stack (
        .clk      (clk),
        .nRst     (nRst),
        .push     (op_s == OP_CALL),
        .pop      (op_s == OP_RET),
        .pushData (addr_inc_s),
        .topData  (top_s),
        .depth    (stackDepth),
        .full     (stk_full_s),
        .empty    (stk_empty_s)
    );

    // Next-address selection from the decoded operation
    always_comb begin
        addr_nxt_s = addr_r;
        case (op_s)
            OP_INC:  addr_nxt_s = addr_inc_s;
            OP_REL:  addr_nxt_s = rel_sum_s;
            OP_ABS:  addr_nxt_s = branchAddress;
            OP_CALL: addr_nxt_s = branchAddress;
            OP_RET:  addr_nxt_s = stk_empty_s ? addr_r : top_s;
            OP_HOLD: addr_nxt_s = addr_r;
            default: addr_nxt_s = addr_r;
        endcase
    end

    assign ovf_set_s = (op_s == OP_CALL) && stk_full_s;
    assign udf_set_s = (op_s == OP_RET) && stk_empty_s;

    // Error-flag next state; a stalled cycle leaves both flags untouched
    always_comb begin
        ovf_nxt_s = ovf_r;
        udf_nxt_s = udf_r;
        if (stall) begin
            ovf_nxt_s = ovf_r;
            udf_nxt_s = udf_r;
        end else begin
`ifdef PC_SEQ_STICKY_ERR_EN
            ovf_nxt_s = ovf_r | ovf_set_s;
            udf_nxt_s = udf_r | udf_set_s;
`else
            ovf_nxt_s = ovf_set_s;
            udf_nxt_s = udf_set_s;
`endif
        end
    end

    // Address and error-flag registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addr_r <= ADDR_RESET;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            addr_r <= addr_nxt_s;
            ovf_r  <= ovf_nxt_s;
            udf_r  <= udf_nxt_s;
        end
    end

    assign addressOut = addr_r;
    assign stackFull  = stk_full_s;
    assign stackEmpty = stk_empty_s;
    assign overflow   = ovf_r;
    assign underflow  = udf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (P_SIZE=6, P_DEPTH=4).
// A behavioural model (integer address, queue-based stack) runs beside
// the DUT and is compared on every falling clock edge; directed steps
// also pin literal expectations. Honours PC_SEQ_STICKY_ERR_EN.
module tb_pc_sequencer;

`ifdef PC_SEQ_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic [5:0] addressOut;
    logic [5:0] branchAddress = 6'd0;
    logic       inc = 1'b0, branchAbs = 1'b0, branchRel = 1'b0;
    logic       call = 1'b0, ret = 1'b0, stall = 1'b0;
    logic [2:0] stackDepth;
    logic       stackFull, stackEmpty, overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int m_addr = 0;
    int m_stk[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    pc_sequencer #(
        .P_SIZE(6), .P_DEPTH(4), .P_RESET_ADDR(0), .P_SIGNED_REL(1)
    ) dut (
        .clk(clk), .nRst(nRst), .addressOut(addressOut),
        .branchAddress(branchAddress), .inc(inc), .branchAbs(branchAbs),
        .branchRel(branchRel), .call(call), .ret(ret), .stall(stall),
        .stackDepth(stackDepth), .stackFull(stackFull),
        .stackEmpty(stackEmpty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one operation per rising edge, by priority
    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_addr = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (!stall) begin
            bit o, u;
            int off;
            o = 1'b0;
            u = 1'b0;
            if (ret) begin
                if (m_stk.size() > 0) m_addr = m_stk.pop_back();
                else u = 1'b1;
            end else if (call) begin
                if (m_stk.size() < 4) m_stk.push_back((m_addr + 1) % 64);
                else o = 1'b1;
                m_addr = int'(branchAddress);
            end else if (branchAbs) begin
                m_addr = int'(branchAddress);
            end else if (branchRel) begin
                off = int'(branchAddress);
                if (off >= 32) off = off - 64;
                m_addr = ((m_addr + off) % 64 + 64) % 64;
            end else if (inc) begin
                m_addr = (m_addr + 1) % 64;
            end
            m_ovf = STICKY ? (m_ovf | o) : o;
            m_udf = STICKY ? (m_udf | u) : u;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("addr", int'(addressOut), m_addr);
        check("depth", int'(stackDepth), m_stk.size());
        check("full", int'(stackFull), int'(m_stk.size() == 4));
        check("empty", int'(stackEmpty), int'(m_stk.size() == 0));
        check("overflow", int'(overflow), int'(m_ovf));
        check("underflow", int'(underflow), int'(m_udf));
    end

    // Present one cycle of strobes, let the edge take them, then clear
    task automatic apply(input logic [5:0] b, input logic i_inc, input logic i_abs,
                         input logic i_rel, input logic i_call, input logic i_ret,
                         input logic i_stall);
        branchAddress = b;
        inc = i_inc; branchAbs = i_abs; branchRel = i_rel;
        call = i_call; ret = i_ret; stall = i_stall;
        @(posedge clk);
        #2;
        inc = 1'b0; branchAbs = 1'b0; branchRel = 1'b0;
        call = 1'b0; ret = 1'b0; stall = 1'b0;
    endtask

    initial begin
        #1 nRst = 1'b0;
        #2;
        check("rst_addr", int'(addressOut), 0);
        check("rst_depth", int'(stackDepth), 0);
        check("rst_empty", int'(stackEmpty), 1);
        check("rst_ovf", int'(overflow), 0);
        #4 nRst = 1'b1;

        // Increment through the full address space and wrap
        for (int k = 0; k < 64; k++) begin
            apply(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 62) check("inc_top", int'(addressOut), 63);
            if (k == 63) check("inc_wrap", int'(addressOut), 0);
        end

        // Absolute and relative branching
        apply(6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abs5", int'(addressOut), 5);
        apply(6'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rel_p8", int'(addressOut), 13);
        apply(6'b111101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rel_m3", int'(addressOut), 10);
        apply(6'd62, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(6'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rel_wrap", int'(addressOut), 2);

        // Nested call / return from 10
        apply(6'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(6'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("call1_addr", int'(addressOut), 20);
        check("call1_depth", int'(stackDepth), 1);
        apply(6'd30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("call2_addr", int'(addressOut), 30);
        check("call2_depth", int'(stackDepth), 2);
        apply(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ret1_addr", int'(addressOut), 21);
        apply(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ret2_addr", int'(addressOut), 11);
        check("ret2_depth", int'(stackDepth), 0);

        // Five calls to 40 from 0: stack saturates, overflow on the fifth
        apply(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            apply(6'd40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("ovf_seq", int'(overflow), int'(k == 4));
        end
        check("ovf_depth", int'(stackDepth), 4);
        check("ovf_full", int'(stackFull), 1);
        check("ovf_addr", int'(addressOut), 40);
        apply(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_after", int'(overflow), int'(STICKY));

        // Drain: 41,41,41 then 1; then a return on an empty stack
        for (int k = 0; k < 4; k++) begin
            apply(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("drain_addr", int'(addressOut), (k == 3) ? 1 : 41);
        end
        apply(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("udf_addr", int'(addressOut), 1);
        check("udf_pulse", int'(underflow), 1);
        apply(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("udf_after", int'(underflow), int'(STICKY));

        // Stall beats everything; without it call beats inc
        apply(6'd50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stall_addr", int'(addressOut), 1);
        check("stall_depth", int'(stackDepth), 0);
        apply(6'd50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("call_wins", int'(addressOut), 50);
        check("call_wins_d", int'(stackDepth), 1);

        // Asynchronous reset with two entries on the stack
        apply(6'd60, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_depth", int'(stackDepth), 2);
        nRst = 1'b0;
        #1;
        check("arst_addr", int'(addressOut), 0);
        check("arst_depth", int'(stackDepth), 0);
        check("arst_udf", int'(underflow), 0);
        @(posedge clk);
        #2 nRst = 1'b1;

        // Randomised traffic, checked every cycle by the compare process
        for (int k = 0; k < 3000; k++) begin
            apply(6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1) == 0),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 699) == 0) begin
                nRst = 1'b0;
                #1;
                check("rnd_arst_addr", int'(addressOut), 0);
                @(posedge clk);
                #2 nRst = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the single-register program counter used in the picoMIPS datapath.
- Adds a hardware return-address stack (call/return), signed or unsigned relative branching, a configurable reset vector and a stall input.
- Drives the program-memory address each cycle.
- Sits between the instruction decoder (which supplies the control strobes) and program ROM.

Parameters:
- P_SIZE, 6: address width in bits; all address arithmetic is modulo 2^P_SIZE.
- P_DEPTH, 4: return-stack entries; must be >= 1.
- P_RESET_ADDR, 0: value loaded into addressOut on reset.
- P_SIGNED_REL, 1: 1 means branchAddress is a two's-complement offset for branchRel; 0 means it is an unsigned offset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nRst  input  1  asynchronous, active-low reset.
- addressOut  output  P_SIZE  current program address (registered).
- branchAddress  input  P_SIZE  absolute target (branchAbs, call) or offset (branchRel).
- inc  input  1  advance to addressOut+1.
- branchAbs  input  1  load branchAddress.
- branchRel  input  1  add offset to addressOut.
- call  input  1  push addressOut+1, jump to branchAddress.
- ret  input  1  pop return stack into addressOut.
- stall  input  1  freeze all state this cycle.
- stackDepth  output  $clog2(P_DEPTH+1)  number of valid stack entries.
- stackFull  output  1  stackDepth == P_DEPTH (combinational from stackDepth).
- stackEmpty  output  1  stackDepth == 0.
- overflow  output  1  registered error flag.
- underflow  output  1  registered error flag.

Behaviour:
- Reset (async, nRst low):
  - addressOut = P_RESET_ADDR; stackDepth = 0; overflow = underflow = 0.
  - Stack contents are don't-care.
  - Reset asserted mid-call/return discards any pending operation.
- One operation per cycle; the result is visible on addressOut one clock after the strobe (latency 1).
- Priority when strobes coincide: stall > ret > call > branchAbs > branchRel > inc > hold.
- stall=1: addressOut, stack and flags all unchanged; error flags also hold their value.
- ret:
  - Not empty: addressOut <= top entry; stackDepth decrements.
  - Empty: addressOut holds; underflow pulses for 1 cycle.
- call:
  - Not full: push (addressOut+1) mod 2^P_SIZE; addressOut <= branchAddress; stackDepth increments.
  - Full: jump still taken, push suppressed, stackDepth unchanged; overflow pulses for 1 cycle.
- branchAbs: addressOut <= branchAddress.
- branchRel: addressOut <= addressOut + ext(branchAddress), where ext is sign-extension if P_SIGNED_REL=1, zero otherwise; result truncated to P_SIZE (wraps).
- inc: addressOut <= addressOut+1; P_SIZE'(2^P_SIZE-1) wraps to 0.
- No strobe: hold.
- Pushed return address of a call at the top address wraps to 0.
- Without the optional feature, overflow/underflow are single-cycle pulses, deasserted on the next non-stalled cycle.
- Stack is LIFO; the entry read on ret is the most recently pushed still-valid entry.

Optional Feature:
- Macro PC_SEQ_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky; once set they stay 1 until nRst.
- Not defined: single-cycle pulse behaviour as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package pc_seq_pkg holds:
  - enum pc_op_t {OP_HOLD, OP_INC, OP_REL, OP_ABS, OP_CALL, OP_RET}.
  - Function decode_op(stall, ret, call, branchAbs, branchRel, inc) implementing the priority order.
- Sub-module pc_return_stack (parameters P_SIZE, P_DEPTH):
  - Register array plus pointer.
  - Ports: push, pop, pushData, topData, depth, full, empty, clk, nRst.
  - Ignores push when full and pop when empty.
- pc_sequencer holds the address register, next-address mux and flag logic.

Test Plan (P_SIZE=6, P_DEPTH=4, P_RESET_ADDR=0, P_SIGNED_REL=1):
- Reset then inc for 64 cycles -> addressOut steps 0..63, then wraps to 0; stackEmpty=1 throughout.
- branchAbs with 5, then branchRel with 8 -> addressOut 5 then 13; branchRel with 6'b111101 (-3) from 13 -> 10; branchRel with +4 from 62 -> 2.
- From 10: call 20, call 30, ret, ret:
  - After the calls, addressOut=20 then 30, stackDepth=1 then 2.
  - After the returns, addressOut=21 then 11, stackDepth back to 0.
- Five consecutive calls to 40 from 0 -> stackDepth saturates at 4, overflow=1 on the 5th cycle only.
- ret on empty -> addressOut unchanged, underflow pulses.
- Rebuild with PC_SEQ_STICKY_ERR_EN -> overflow/underflow flags remain 1 until nRst.
- inc+call+stall together -> no change; drop stall -> call wins over inc.
- Assert nRst low mid-call sequence (stackDepth=2) -> addressOut=0 and stackDepth=0 immediately, without waiting for a clock edge.
